// File: rtl/odyssey_video_timing_if.sv
// Raster timing bundle between the Odyssey timing generator and the video path.
// The master drives the raster outputs; the slave supplies the video mode selects.
interface odyssey_video_timing_if;
    logic       pal;
    logic       scandouble;
    logic       ce_pix;
    logic [8:0] hcount;
    logic [8:0] vcount;
    logic       line_rep;
    logic       HBlank;
    logic       HSync;
    logic       VBlank;
    logic       VSync;
    logic       frame_start;
    logic [7:0] frame_cnt;

    modport master (
        input  pal,
        input  scandouble,
        output ce_pix,
        output hcount,
        output vcount,
        output line_rep,
        output HBlank,
        output HSync,
        output VBlank,
        output VSync,
        output frame_start,
        output frame_cnt
    );

    modport slave (
        output pal,
        output scandouble,
        input  ce_pix,
        input  hcount,
        input  vcount,
        input  line_rep,
        input  HBlank,
        input  HSync,
        input  VBlank,
        input  VSync,
        input  frame_start,
        input  frame_cnt
    );
endinterface

// File: rtl/odyssey_video_timing.sv
// Odyssey raster timing generator: pixel enable, raster position, blanking and sync
// for NTSC/PAL, with optional 2x scandoubled line rate. All outputs move on ce_pix.
module odyssey_video_timing #(
    parameter int CLK_DIV    = 4,
    parameter int H_ACTIVE   = 256,
    parameter int H_FP       = 24,
    parameter int H_SYNC     = 32,
    parameter int H_BP       = 28,
    parameter int V_ACTIVE_N = 240,
    parameter int V_FP_N     = 3,
    parameter int V_SYNC_N   = 3,
    parameter int V_BP_N     = 16,
    parameter int V_ACTIVE_P = 288,
    parameter int V_FP_P     = 3,
    parameter int V_SYNC_P   = 3,
    parameter int V_BP_P     = 18
) (
    input  logic                  clk,
    input  logic                  reset,
    odyssey_video_timing_if.master vid
);
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL_N = V_ACTIVE_N + V_FP_N + V_SYNC_N + V_BP_N;
    localparam int V_TOTAL_P = V_ACTIVE_P + V_FP_P + V_SYNC_P + V_BP_P;
    localparam int DIV_W     = $clog2(CLK_DIV) + 1;

    localparam logic [DIV_W-1:0] DIV_ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST_1X = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAST_2X = DIV_W'(CLK_DIV / 2 - 1);

    localparam logic [8:0] H_LAST        = 9'(H_TOTAL - 1);
    localparam logic [8:0] H_BLANK_START = 9'(H_ACTIVE);
    localparam logic [8:0] H_SYNC_START  = 9'(H_ACTIVE + H_FP);
    localparam logic [8:0] H_SYNC_END    = 9'(H_ACTIVE + H_FP + H_SYNC);

    localparam logic [8:0] V_LAST_N        = 9'(V_TOTAL_N - 1);
    localparam logic [8:0] V_BLANK_START_N = 9'(V_ACTIVE_N);
    localparam logic [8:0] V_SYNC_START_N  = 9'(V_ACTIVE_N + V_FP_N);
    localparam logic [8:0] V_SYNC_END_N    = 9'(V_ACTIVE_N + V_FP_N + V_SYNC_N);
    localparam logic [8:0] V_LAST_P        = 9'(V_TOTAL_P - 1);
    localparam logic [8:0] V_BLANK_START_P = 9'(V_ACTIVE_P);
    localparam logic [8:0] V_SYNC_START_P  = 9'(V_ACTIVE_P + V_FP_P);
    localparam logic [8:0] V_SYNC_END_P    = 9'(V_ACTIVE_P + V_FP_P + V_SYNC_P);

    function automatic logic in_window(input logic [8:0] x, input logic [8:0] lo,
                                       input logic [8:0] hi);
        return (x >= lo) && (x < hi);
    endfunction

    logic [DIV_W-1:0] div_q, div_d;
    logic             mode_pal_q, mode_pal_d;
    logic             mode_2x_q, mode_2x_d;

    // Position of the next pixel to be emitted; copied to the outputs on ce_pix.
    logic [8:0]       pos_h_q, pos_h_d;
    logic [8:0]       pos_v_q, pos_v_d;
    logic             pos_rep_q, pos_rep_d;
    logic [7:0]       pos_fcnt_q, pos_fcnt_d;

    logic             ce_pix_q, ce_pix_d;
    logic [8:0]       hcount_q, hcount_d;
    logic [8:0]       vcount_q, vcount_d;
    logic             line_rep_q, line_rep_d;
    logic             hblank_q, hblank_d;
    logic             hsync_q, hsync_d;
    logic             vblank_q, vblank_d;
    logic             vsync_q, vsync_d;
    logic             frame_start_q, frame_start_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;

    logic [DIV_W-1:0] div_last_cur;
    logic [DIV_W-1:0] div_last_nxt;
    logic             div_wrap;
    logic             frame_last;
    logic [8:0]       v_last;
    logic [8:0]       v_blank_start;
    logic [8:0]       v_sync_start;
    logic [8:0]       v_sync_end;

    always_comb begin
        mode_pal_d    = mode_pal_q;
        mode_2x_d     = mode_2x_q;
        pos_h_d       = pos_h_q;
        pos_v_d       = pos_v_q;
        pos_rep_d     = pos_rep_q;
        pos_fcnt_d    = pos_fcnt_q;
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        line_rep_d    = line_rep_q;
        hblank_d      = hblank_q;
        hsync_d       = hsync_q;
        vblank_d      = vblank_q;
        vsync_d       = vsync_q;
        frame_cnt_d   = frame_cnt_q;
        frame_start_d = 1'b0;

        v_last        = mode_pal_q ? V_LAST_P        : V_LAST_N;
        v_blank_start = mode_pal_q ? V_BLANK_START_P : V_BLANK_START_N;
        v_sync_start  = mode_pal_q ? V_SYNC_START_P  : V_SYNC_START_N;
        v_sync_end    = mode_pal_q ? V_SYNC_END_P    : V_SYNC_END_N;

        // Modes reload when the last pixel of a frame finishes, so the new divider
        // ratio governs the very first pixel of the next frame.
        div_last_cur = mode_2x_q ? DIV_LAST_2X : DIV_LAST_1X;
        div_wrap     = (div_q == div_last_cur);
        frame_last   = (hcount_q == H_LAST) && (vcount_q == v_last) &&
                       (line_rep_q || !mode_2x_q);
        if (div_wrap && frame_last) begin
            mode_pal_d = vid.pal;
            mode_2x_d  = vid.scandouble;
        end
        div_last_nxt = mode_2x_d ? DIV_LAST_2X : DIV_LAST_1X;
        div_d        = div_wrap ? '0 : div_q + DIV_ONE;
        ce_pix_d     = (div_d == div_last_nxt);

        if (ce_pix_d) begin
            hcount_d      = pos_h_q;
            vcount_d      = pos_v_q;
            line_rep_d    = pos_rep_q;
            frame_cnt_d   = pos_fcnt_q;
            frame_start_d = (pos_h_q == 9'd0) && (pos_v_q == 9'd0) && !pos_rep_q;
            hblank_d      = (pos_h_q >= H_BLANK_START);
            hsync_d       = in_window(pos_h_q, H_SYNC_START, H_SYNC_END);
            vblank_d      = (pos_v_q >= v_blank_start);
            vsync_d       = in_window(pos_v_q, v_sync_start, v_sync_end);

            if (pos_h_q == H_LAST) begin
                pos_h_d = '0;
                // In 2x mode every source line is emitted twice before vcount moves.
                if (mode_2x_q && !pos_rep_q) begin
                    pos_rep_d = 1'b1;
                end else begin
                    pos_rep_d = 1'b0;
                    if (pos_v_q == v_last) begin
                        pos_v_d    = '0;
                        pos_fcnt_d = pos_fcnt_q + 8'd1;
                    end else begin
                        pos_v_d = pos_v_q + 9'd1;
                    end
                end
            end else begin
                pos_h_d = pos_h_q + 9'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q         <= '0;
            mode_pal_q    <= vid.pal;
            mode_2x_q     <= vid.scandouble;
            pos_h_q       <= '0;
            pos_v_q       <= '0;
            pos_rep_q     <= 1'b0;
            pos_fcnt_q    <= '0;
            ce_pix_q      <= 1'b0;
            hcount_q      <= '0;
            vcount_q      <= '0;
            line_rep_q    <= 1'b0;
            hblank_q      <= 1'b0;
            hsync_q       <= 1'b0;
            vblank_q      <= 1'b0;
            vsync_q       <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            div_q         <= div_d;
            mode_pal_q    <= mode_pal_d;
            mode_2x_q     <= mode_2x_d;
            pos_h_q       <= pos_h_d;
            pos_v_q       <= pos_v_d;
            pos_rep_q     <= pos_rep_d;
            pos_fcnt_q    <= pos_fcnt_d;
            ce_pix_q      <= ce_pix_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            line_rep_q    <= line_rep_d;
            hblank_q      <= hblank_d;
            hsync_q       <= hsync_d;
            vblank_q      <= vblank_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign vid.ce_pix      = ce_pix_q;
    assign vid.hcount      = hcount_q;
    assign vid.vcount      = vcount_q;
    assign vid.line_rep    = line_rep_q;
    assign vid.HBlank      = hblank_q;
    assign vid.HSync       = hsync_q;
    assign vid.VBlank      = vblank_q;
    assign vid.VSync       = vsync_q;
    assign vid.frame_start = frame_start_q;
    assign vid.frame_cnt   = frame_cnt_q;
endmodule

// File: tb/tb_odyssey_video_timing.sv
// Bench for odyssey_video_timing with a shrunken raster so whole frames run quickly;
// a pixel-index reference model checks every cycle, plus vector table and corner sequences.
module tb_odyssey_video_timing;
    localparam int CLK_DIV    = 4;
    localparam int H_ACTIVE   = 4;
    localparam int H_FP       = 1;
    localparam int H_SYNC     = 2;
    localparam int H_BP       = 1;
    localparam int H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_ACTIVE_N = 3;
    localparam int V_FP_N     = 1;
    localparam int V_SYNC_N   = 1;
    localparam int V_BP_N     = 1;
    localparam int V_ACTIVE_P = 4;
    localparam int V_FP_P     = 1;
    localparam int V_SYNC_P   = 2;
    localparam int V_BP_P     = 1;
    localparam int V_TOTAL_N  = V_ACTIVE_N + V_FP_N + V_SYNC_N + V_BP_N;
    localparam int V_TOTAL_P  = V_ACTIVE_P + V_FP_P + V_SYNC_P + V_BP_P;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    odyssey_video_timing_if vif ();

    odyssey_video_timing #(
        .CLK_DIV(CLK_DIV), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE_N(V_ACTIVE_N), .V_FP_N(V_FP_N), .V_SYNC_N(V_SYNC_N), .V_BP_N(V_BP_N),
        .V_ACTIVE_P(V_ACTIVE_P), .V_FP_P(V_FP_P), .V_SYNC_P(V_SYNC_P), .V_BP_P(V_BP_P)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .vid  (vif)
    );

    typedef struct {
        bit   pal;
        bit   sd;
        int   h;
        int   v;
        bit   rep;
        int   cyc;
        logic [3:0] flags;
    } vec_t;

    typedef struct {
        int clocks;
        int ces;
        int maxv;
        int vbmin;
        int vsmin;
        int vsmax;
        int reps;
        int fc_next;
        bit ok;
    } frame_stats_t;

    vec_t tbl [13];

    int checks = 0;
    int errors = 0;
    int rel = 0;
    int fs_count = 0;
    int fs_wide = 0;
    bit prev_fs = 1'b0;
    int model_msgs = 0;

    // Reference model: pixel index within the frame plus clock phase within the pixel slot.
    int m_c = 1;
    int m_pix = 0;
    int m_frame = 0;
    bit m_pal = 1'b0;
    bit m_2x = 1'b0;
    bit e_ce = 1'b0, e_fs = 1'b0, e_rep = 1'b0;
    bit e_hb = 1'b0, e_hs = 1'b0, e_vb = 1'b0, e_vs = 1'b0;
    int e_h = 0, e_v = 0, e_fc = 0;

    function automatic int per();
        return m_2x ? CLK_DIV / 2 : CLK_DIV;
    endfunction

    function automatic int npix();
        return H_TOTAL * (m_pal ? V_TOTAL_P : V_TOTAL_N) * (m_2x ? 2 : 1);
    endfunction

    function automatic void model_edge();
        int line, va, vs0, vsw;
        if (reset) begin
            m_c = 1; m_pix = 0; m_frame = 0;
            m_pal = vif.pal; m_2x = vif.scandouble;
            e_ce = 0; e_fs = 0; e_rep = 0; e_hb = 0; e_hs = 0; e_vb = 0; e_vs = 0;
            e_h = 0; e_v = 0; e_fc = 0;
        end else begin
            if (m_c == per()) begin
                m_c = 1;
                if (m_pix == npix() - 1) begin
                    m_pix = 0;
                    m_frame++;
                    m_pal = vif.pal;
                    m_2x  = vif.scandouble;
                end else begin
                    m_pix++;
                end
            end else begin
                m_c++;
            end
            e_ce = (m_c == per());
            e_fs = e_ce && (m_pix == 0);
            if (e_ce) begin
                line  = m_pix / H_TOTAL;
                e_h   = m_pix % H_TOTAL;
                e_v   = m_2x ? line / 2 : line;
                e_rep = m_2x ? (line % 2 == 1) : 1'b0;
                va    = m_pal ? V_ACTIVE_P : V_ACTIVE_N;
                vs0   = va + (m_pal ? V_FP_P : V_FP_N);
                vsw   = m_pal ? V_SYNC_P : V_SYNC_N;
                e_hb  = (e_h >= H_ACTIVE);
                e_hs  = (e_h >= H_ACTIVE + H_FP) && (e_h < H_ACTIVE + H_FP + H_SYNC);
                e_vb  = (e_v >= va);
                e_vs  = (e_v >= vs0) && (e_v < vs0 + vsw);
                e_fc  = m_frame % 256;
            end
        end
    endfunction

    function automatic logic [32:0] outvec();
        return {vif.ce_pix, vif.frame_start, vif.hcount, vif.vcount, vif.line_rep,
                vif.HBlank, vif.HSync, vif.VBlank, vif.VSync, vif.frame_cnt};
    endfunction

    function automatic void chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    task automatic step();
        logic [32:0] act, exp;
        @(posedge clk);
        model_edge();
        #1;
        rel++;
        act = outvec();
        exp = {e_ce, e_fs, 9'(e_h), 9'(e_v), e_rep, e_hb, e_hs, e_vb, e_vs, 8'(e_fc)};
        checks++;
        if (act !== exp) begin
            errors++;
            if (model_msgs < 10)
                $display("FAIL model t=%0t got %h expected %h", $time, act, exp);
            model_msgs++;
        end
        if (vif.frame_start) begin
            fs_count++;
            if (prev_fs) fs_wide++;
        end
        prev_fs = vif.frame_start;
    endtask

    task automatic do_reset(input bit p, input bit s);
        vif.pal = p;
        vif.scandouble = s;
        reset = 1'b1;
        step();
        reset = 1'b0;
        rel = 1;
    endtask

    task automatic wait_match(input int h, input int v, input bit r, input int budget,
                              output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            step();
            if (vif.ce_pix && vif.hcount == 9'(h) && vif.vcount == 9'(v) && vif.line_rep == r) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_fs(input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            step();
            if (vif.frame_start) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_frame(output frame_stats_t st);
        st = '{0, 0, -1, 999, 999, -1, 0, -1, 1'b0};
        for (int n = 0; n < 2000; n++) begin
            if (vif.ce_pix) begin
                st.ces++;
                if (int'(vif.vcount) > st.maxv) st.maxv = int'(vif.vcount);
                if (vif.VBlank && int'(vif.vcount) < st.vbmin) st.vbmin = int'(vif.vcount);
                if (vif.VSync && int'(vif.vcount) < st.vsmin) st.vsmin = int'(vif.vcount);
                if (vif.VSync && int'(vif.vcount) > st.vsmax) st.vsmax = int'(vif.vcount);
                if (vif.line_rep) st.reps++;
            end
            step();
            st.clocks++;
            if (vif.frame_start) begin
                st.ok = 1'b1;
                st.fc_next = int'(vif.frame_cnt);
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        frame_stats_t st;

        vif.pal = 1'b0;
        vif.scandouble = 1'b0;

        // {pal, scandouble, h, v, line_rep, clocks from reset release, {HB,HS,VB,VS}}
        tbl[0]  = '{1'b0, 1'b0, 0, 0, 1'b0,   4, 4'b0000};
        tbl[1]  = '{1'b0, 1'b0, 4, 0, 1'b0,  20, 4'b1000};
        tbl[2]  = '{1'b0, 1'b0, 5, 0, 1'b0,  24, 4'b1100};
        tbl[3]  = '{1'b0, 1'b0, 6, 2, 1'b0,  92, 4'b1100};
        tbl[4]  = '{1'b0, 1'b0, 7, 3, 1'b0, 128, 4'b1010};
        tbl[5]  = '{1'b0, 1'b0, 3, 4, 1'b0, 144, 4'b0011};
        tbl[6]  = '{1'b0, 1'b0, 0, 5, 1'b0, 164, 4'b0010};
        tbl[7]  = '{1'b1, 1'b0, 2, 3, 1'b0, 108, 4'b0000};
        tbl[8]  = '{1'b1, 1'b0, 1, 5, 1'b0, 168, 4'b0011};
        tbl[9]  = '{1'b1, 1'b0, 0, 7, 1'b0, 228, 4'b0010};
        tbl[10] = '{1'b0, 1'b1, 0, 0, 1'b1,  18, 4'b0000};
        tbl[11] = '{1'b0, 1'b1, 5, 4, 1'b1, 156, 4'b1111};
        tbl[12] = '{1'b1, 1'b1, 7, 6, 1'b0, 208, 4'b1011};

        do_reset(1'b0, 1'b0);
        chk("reset_state", longint'(outvec()), 0);

        for (int i = 0; i < 13; i++) begin
            do_reset(tbl[i].pal, tbl[i].sd);
            wait_match(tbl[i].h, tbl[i].v, tbl[i].rep, 400, ok);
            chk($sformatf("tbl%0d_cycle", i), ok ? rel : -1, tbl[i].cyc);
            chk($sformatf("tbl%0d_flags", i),
                {vif.HBlank, vif.HSync, vif.VBlank, vif.VSync}, tbl[i].flags);
        end

        // Full NTSC frame from reset.
        do_reset(1'b0, 1'b0);
        wait_fs(20, ok);
        chk("ntsc_first_fs", ok, 1);
        chk("ntsc_first_fs_cycle", rel, 4);
        run_frame(st);
        chk("ntsc_frame_ok", st.ok, 1);
        chk("ntsc_clocks", st.clocks, 192);
        chk("ntsc_maxv", st.maxv, 5);
        chk("ntsc_vblank_start", st.vbmin, 3);
        chk("ntsc_vsync_first", st.vsmin, 4);
        chk("ntsc_vsync_last", st.vsmax, 4);
        chk("ntsc_frame_cnt", st.fc_next, 1);

        // pal raised mid-frame: current frame keeps NTSC length, next is PAL.
        wait_match(0, 2, 1'b0, 400, ok);
        chk("pal_toggle_reach", ok, 1);
        vif.pal = 1'b1;
        run_frame(st);
        chk("pal_toggle_old_maxv", st.maxv, 5);
        chk("pal_toggle_old_fc", st.fc_next, 2);
        run_frame(st);
        chk("pal_clocks", st.clocks, 256);
        chk("pal_maxv", st.maxv, 7);
        chk("pal_vblank_start", st.vbmin, 4);
        chk("pal_vsync_first", st.vsmin, 5);
        chk("pal_vsync_last", st.vsmax, 6);
        chk("pal_frame_cnt", st.fc_next, 3);

        // One-clock reset in the middle of a frame.
        vif.pal = 1'b0;
        wait_match(5, 3, 1'b0, 400, ok);
        chk("midreset_reach", ok, 1);
        reset = 1'b1;
        step();
        chk("midreset_zero", longint'(outvec()), 0);
        reset = 1'b0;
        rel = 1;
        wait_fs(20, ok);
        chk("midreset_fs", ok, 1);
        chk("midreset_cycle", rel, 4);
        chk("midreset_pos", {vif.hcount, vif.vcount, vif.line_rep}, 0);
        chk("midreset_fc", vif.frame_cnt, 0);

        // Scandoubled frame from reset.
        do_reset(1'b0, 1'b1);
        wait_fs(20, ok);
        chk("sd_first_fs_cycle", ok ? rel : -1, 2);
        run_frame(st);
        chk("sd_clocks", st.clocks, 192);
        chk("sd_pixels", st.ces, 96);
        chk("sd_repeats", st.reps, 48);
        chk("sd_maxv", st.maxv, 5);

        // Random mode toggles and occasional resets against the model.
        do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 2) vif.pal = ~vif.pal;
            if ($urandom_range(0, 99) < 2) vif.scandouble = ~vif.scandouble;
            reset = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 1'b0;

        // 256 NTSC frames: frame_cnt wrap and single-clock frame_start pulses.
        do_reset(1'b0, 1'b0);
        wait_fs(20, ok);
        chk("wrap_first_fs", ok, 1);
        fs_count = 0;
        fs_wide = 0;
        for (int f = 1; f <= 256; f++) begin
            run_frame(st);
            chk("wrap_frame_clocks", st.clocks, 192);
            if (f == 255) chk("wrap_fc_255", st.fc_next, 255);
        end
        chk("wrap_fc_0", st.fc_next, 0);
        chk("wrap_fs_count", fs_count, 256);
        chk("wrap_fs_wide", fs_wide, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/odyssey_video_timing.md
Name: odyssey_video_timing

Overview:
- Raster timing generator inside the Odyssey core; sits directly upstream of the pixel/video generator and of the emu-level VGA_* assignments.
- Produces the pixel clock enable, blanking, sync, and raster position (hcount/vcount) for NTSC or PAL.
- Optional 2x scandoubled line rate.
- All outputs are registered and aligned to the same ce_pix edge.

Parameters:
- CLK_DIV, 4: clk cycles per pixel in 1x mode; must be even and at least 2. In 2x mode a pixel is CLK_DIV/2 clocks.
- H_ACTIVE, 256: visible pixels per line.
- H_FP, 24: front-porch pixels.
- H_SYNC, 32: hsync width in pixels.
- H_BP, 28: back-porch pixels. H_TOTAL = 340.
- V_ACTIVE_N, 240 / V_FP_N, 3 / V_SYNC_N, 3 / V_BP_N, 16: NTSC line counts, total 262.
- V_ACTIVE_P, 288 / V_FP_P, 3 / V_SYNC_P, 3 / V_BP_P, 18: PAL line counts, total 312.

Ports:
- clk  in  1  system clock (clk_sys)
- reset  in  1  synchronous, active-high
- pal  in  1  0 = NTSC, 1 = PAL; sampled only at frame start
- scandouble  in  1  1 = emit each source line twice at 2x pixel rate; sampled only at frame start
- ce_pix  out  1  one-clk pulse per output pixel
- hcount  out  9  pixel index in line, 0..H_TOTAL-1
- vcount  out  9  source line index in frame, 0..V_TOTAL-1
- line_rep  out  1  in 2x mode: 0 = first copy of a source line, 1 = repeat; always 0 in 1x mode
- HBlank  out  1  high when hcount >= H_ACTIVE
- HSync  out  1  high when H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC
- VBlank  out  1  high when vcount >= V_ACTIVE
- VSync  out  1  high when V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC
- frame_start  out  1  one-clk pulse coincident with ce_pix at hcount=0, vcount=0, line_rep=0
- frame_cnt  out  8  frames since reset, wraps 255 -> 0

Behaviour:
- Reset values:
  - Outputs: ce_pix=0, hcount=0, vcount=0, line_rep=0, HBlank=0, HSync=0, VBlank=0, VSync=0, frame_start=0, frame_cnt=0.
  - Internals: divider=0. mode_pal and mode_2x load from pal and scandouble.
- Divider:
  - Counts 0..div_max-1, where div_max = CLK_DIV in 1x mode and CLK_DIV/2 in 2x mode.
  - ce_pix=1 in the clk cycle where divider==div_max-1; divider then wraps to 0.
  - The first ce_pix after reset is asserted on clk cycle div_max (counting reset release as cycle 1).
- Counters advance only on ce_pix, and the outputs shown with a ce_pix pulse describe the pixel being emitted on that pulse.
  - The first ce_pix after reset shows hcount=0, vcount=0, frame_start=1.
  - Subsequent ce_pix advance the counters in order.
- Horizontal: hcount increments per pixel; at H_TOTAL-1 it wraps to 0 and ends the line.
- Line end:
  - 1x mode: vcount increments.
  - 2x mode: if line_rep=0, set line_rep=1 and hold vcount; else clear line_rep and increment vcount.
- Frame end: line end at vcount = V_TOTAL-1 (and line_rep=1 in 2x mode).
  - vcount wraps to 0.
  - frame_cnt increments.
  - mode_pal and mode_2x reload from pal and scandouble; the new div_max takes effect from the next pixel.
  - V_TOTAL is 262 or 312 per mode_pal.
- Mid-frame changes of pal or scandouble have no effect until the next frame end; no partial or short frames.
- Decode:
  - HBlank, HSync, VBlank, VSync decode combinationally from the next counter values and are registered together with the counters, so they align exactly with hcount/vcount.
  - Sync polarity is active-high.
  - Between ce_pix pulses all outputs hold their values.
- reset asserted mid-frame: every state returns to its reset value on the next clk edge. No ce_pix is produced while reset is high.
- Line rates:
  - 1x mode: one line is 340·CLK_DIV clk cycles.
  - 2x mode: one output line is 340·CLK_DIV/2 cycles, so each source line still spans 340·CLK_DIV cycles.

Test Plan:
- Reset release, CLK_DIV=4, pal=0, scandouble=0 -> first ce_pix on cycle 4, then every 4 clks; first pulse shows hcount=0, vcount=0, frame_start=1; HBlank rises at hcount=256, HSync spans 280..311.
- NTSC full frame -> vcount wraps after 261, VBlank over 240..261, VSync over 243..245; frame spans 262·340·4 = 356,320 clks; frame_cnt=1 after the first wrap.
- pal toggled 0->1 at vcount=100 -> current frame still ends after line 261; next frame has 312 lines, VSync over 291..293.
- scandouble=1 from reset -> ce_pix every 2 clks; each vcount is held for two lines with line_rep 0 then 1; frame still spans 356,320 clks.
- reset pulsed for one clk at hcount=150, vcount=77 -> next cycle all outputs are 0; after release the raster restarts at (0,0) with frame_start=1 and frame_cnt=0.
- Run 256 NTSC frames -> frame_cnt wraps 255 -> 0; frame_start pulses exactly once per frame, each pulse one clk wide.
